uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- 8N1 UART receiver with 16x oversampling.
- Consumes the 16x-oversample enable from the UART baud generator (rxclk_en, one clk_50m-wide pulse per oversample tick).
- Deserialises the rx line and presents each byte with a ready flag, plus sticky frame-error and overrun flags, to the host side.
- Sits beside the transmitter in the UART top level and shares the same baud generator.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- OVERSAMPLE, 16, rxclk_en ticks per bit period; must be a power of two, at least 8.

Ports:
- clk_50m  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous, active-low reset
- rxclk_en  input  1  oversample tick, one clock wide
- rx  input  1  serial line, asynchronous, idle high
- rdy_clr  input  1  host acknowledge; clears rdy, frame_err and overrun
- data  output  DATA_BITS  last received byte
- rdy  output  1  byte available
- frame_err  output  1  stop bit of the last frame sampled low
- overrun  output  1  a byte completed while rdy was still 1
- busy  output  1  receiver state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt=0; bitpos=0; shift register=0.
  - data=0, rdy=0, frame_err=0, overrun=0, busy=0.
  - Both synchroniser flops = 1.
  - Reset mid-frame abandons the frame with no output.
- Synchroniser: rx passes through two flops to give rx_s. All sampling uses rx_s.
- Timing of updates:
  - State, cnt and bitpos advance only on clocks where rxclk_en=1.
  - rdy_clr is honoured on every clock.
- cnt is log2(OVERSAMPLE) bits. Its wrap is explicit: reset to 0 at OVERSAMPLE-1, never overflowed.
- States:
  - IDLE: on a tick with rx_s=0, go to START with cnt=0.
  - START: on each tick, if rx_s=1, return to IDLE (glitch reject). Otherwise, if cnt=OVERSAMPLE/2-1, go to DATA with cnt=0 and bitpos=0; else cnt+1. This aligns sampling to mid-bit.
  - DATA: on each tick, cnt+1. When cnt=OVERSAMPLE-1:
    - shift rx_s into position bitpos (LSB first) and set cnt=0;
    - if bitpos=DATA_BITS-1, go to STOP; else bitpos+1.
  - STOP: on each tick, cnt+1. When cnt=OVERSAMPLE-1, run completion:
    - data <= shift register; rdy <= 1;
    - frame_err <= ~rx_s;
    - overrun <= overrun | rdy (old value).
    - Next state: IDLE if rx_s=1, else BREAK.
  - BREAK: stay until a tick with rx_s=1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- busy = (state != IDLE).
- Latency: outputs update on the clock edge of the completion tick, registered. The mid-stop-bit sample falls about 9.5 bit periods after the start edge.
- rdy_clr handling:
  - Without completion in the same cycle: rdy, frame_err and overrun all clear to 0 on the next edge.
  - With completion in the same cycle: completion wins, so rdy=1 and frame_err is from the new frame. overrun takes the value computed from the old rdy, ignoring the clear.
- Overrun: data is overwritten with the newest byte; overrun stays set until rdy_clr.
- A frame error still delivers the byte, with rdy=1.
- rdy_clr with rdy=0 has no effect.
- rx transitions between ticks are ignored; only tick samples matter.
- At 50 MHz, rxclk_en has a period of 28 clocks, so one bit period is 448 clocks.

Test Plan:
- Drive 0x55 as 8N1 with a 448-clock bit period -> exactly one rdy rise; data=0x55, frame_err=0, overrun=0; busy returns to 0 after the stop-bit sample.
- Pulse rx low for 3 ticks (84 clocks), then hold high -> state returns to IDLE; rdy stays 0 and data is unchanged.
- Send 0xA3 with the stop bit driven low, hold rx low for 5 more bits, then release:
  - rdy=1, data=0xA3, frame_err=1, and busy stays 1 while low;
  - after release, pulse rdy_clr and send 0x3C -> data=0x3C, frame_err=0.
- Send 0x01 then 0xFF back to back with no rdy_clr -> data=0xFF, rdy=1, overrun=1; a later rdy_clr clears all three flags.
- Assert rdy_clr on the exact completion cycle of a second byte while rdy=1 -> rdy stays 1, overrun=1, data is the new byte.
- Assert rst_n=0 during bit 4 of a frame -> all outputs 0 immediately; after release, 0xC9 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling: synchronises rx, samples each bit
// at mid-period and hands bytes to the host with sticky frame/overrun flags.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int POS_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [POS_W-1:0]     bitpos;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_s;

    // NOTE: the synchroniser resets to the idle-high line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bitpos    <= '0;
            shift_reg <= '0;
            data      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rdy_clr) begin
                rdy       <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            // NOTE: the completion assignments below come after the clear, so
            // with non-blocking semantics a byte finishing on the same clock
            // as rdy_clr overrides it; overrun still sees the pre-edge rdy.
            if (rxclk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else if (cnt == CNT_HALF) begin
                            state  <= ST_DATA;
                            cnt    <= '0;
                            bitpos <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt               <= '0;
                            shift_reg[bitpos] <= rx_s;
                            if (bitpos == POS_LAST) begin
                                state <= ST_STOP;
                            end else begin
                                bitpos <= bitpos + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            data      <= shift_reg;
                            rdy       <= 1'b1;
                            frame_err <= ~rx_s;
                            overrun   <= overrun | rdy;
                            state     <= rx_s ? ST_IDLE : ST_BREAK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // A held-low line must return high before a new start bit counts.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames driven at 448 clocks per bit with a
// 28-clock oversample tick, expected values hand-computed.
module tb_uart_rx_core;

    localparam int BIT_CLKS  = 448;
    localparam int TICK_CLKS = 28;

    logic       clk_50m  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rxclk_en = 1'b0;
    logic       rx       = 1'b1;
    logic       rdy_clr  = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors    = 0;
    int checks    = 0;
    int tick_cnt  = 0;
    int rdy_rises = 0;
    logic rdy_prev = 1'b0;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rxclk_en  (rxclk_en),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk_50m = ~clk_50m;

    // Free-running oversample tick: rxclk_en is high exactly when tick_cnt == 0.
    always @(posedge clk_50m) begin
        tick_cnt <= (tick_cnt == TICK_CLKS - 1) ? 0 : tick_cnt + 1;
        rxclk_en <= (tick_cnt == TICK_CLKS - 1);
    end

    always @(negedge clk_50m) begin
        if (rdy && !rdy_prev) rdy_rises++;
        rdy_prev = rdy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    // Park on the negedge just before a tick so frame timing is deterministic.
    task automatic align();
        @(negedge clk_50m);
        while (tick_cnt != 0) @(negedge clk_50m);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_negs(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_negs(BIT_CLKS);
        end
        rx = stop_bit;
        wait_negs(BIT_CLKS);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        wait_negs(1);
        rdy_clr = 1'b0;
        wait_negs(1);
    endtask

    initial begin
        wait_negs(5);
        check("reset_data", {24'h0, data}, 32'h0);
        check("reset_rdy", {31'h0, rdy}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        wait_negs(5);

        // Clean 0x55 frame.
        align();
        send_frame(8'h55, 1'b1);
        check("t1_rises", rdy_rises, 1);
        check("t1_data", {24'h0, data}, 32'h55);
        check("t1_rdy", {31'h0, rdy}, 32'h1);
        check("t1_ferr", {31'h0, frame_err}, 32'h0);
        check("t1_ovr", {31'h0, overrun}, 32'h0);
        check("t1_busy", {31'h0, busy}, 32'h0);
        pulse_clr();
        check("t1_clr_rdy", {31'h0, rdy}, 32'h0);

        // Three-tick glitch must be rejected.
        align();
        rx = 1'b0;
        wait_negs(3 * TICK_CLKS);
        rx = 1'b1;
        wait_negs(2 * BIT_CLKS);
        check("t2_busy", {31'h0, busy}, 32'h0);
        check("t2_rdy", {31'h0, rdy}, 32'h0);
        check("t2_data", {24'h0, data}, 32'h55);
        check("t2_rises", rdy_rises, 1);

        // Frame error followed by a held-low break.
        align();
        send_frame(8'hA3, 1'b0);
        wait_negs(5 * BIT_CLKS);
        check("t3_rdy", {31'h0, rdy}, 32'h1);
        check("t3_data", {24'h0, data}, 32'hA3);
        check("t3_ferr", {31'h0, frame_err}, 32'h1);
        check("t3_busy_low", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        wait_negs(BIT_CLKS);
        check("t3_busy_rel", {31'h0, busy}, 32'h0);
        pulse_clr();
        check("t3_clr_ferr", {31'h0, frame_err}, 32'h0);
        align();
        send_frame(8'h3C, 1'b1);
        check("t3_data2", {24'h0, data}, 32'h3C);
        check("t3_ferr2", {31'h0, frame_err}, 32'h0);
        check("t3_rdy2", {31'h0, rdy}, 32'h1);

        // Back-to-back bytes without acknowledge -> overrun.
        pulse_clr();
        align();
        send_frame(8'h01, 1'b1);
        check("t4_ovr_first", {31'h0, overrun}, 32'h0);
        send_frame(8'hFF, 1'b1);
        check("t4_data", {24'h0, data}, 32'hFF);
        check("t4_rdy", {31'h0, rdy}, 32'h1);
        check("t4_ovr", {31'h0, overrun}, 32'h1);
        pulse_clr();
        check("t4_clr_rdy", {31'h0, rdy}, 32'h0);
        check("t4_clr_ovr", {31'h0, overrun}, 32'h0);
        check("t4_clr_ferr", {31'h0, frame_err}, 32'h0);
        pulse_clr();
        check("t4_clr_idle_data", {24'h0, data}, 32'hFF);

        // rdy_clr on the exact completion clock: posedge 4285 after the aligned start.
        align();
        send_frame(8'h5A, 1'b1);
        check("t5_first_rdy", {31'h0, rdy}, 32'h1);
        align();
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_negs(4284);
                rdy_clr = 1'b1;
                wait_negs(1);
                rdy_clr = 1'b0;
            end
        join
        check("t5_rdy", {31'h0, rdy}, 32'h1);
        check("t5_ovr", {31'h0, overrun}, 32'h1);
        check("t5_data", {24'h0, data}, 32'h96);
        check("t5_ferr", {31'h0, frame_err}, 32'h0);

        // Reset during bit 4 abandons the frame.
        align();
        rx = 1'b0;
        wait_negs(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            wait_negs(BIT_CLKS);
        end
        wait_negs(200);
        check("t6_busy_mid", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", {24'h0, data}, 32'h0);
        check("t6_rst_rdy", {31'h0, rdy}, 32'h0);
        check("t6_rst_ovr", {31'h0, overrun}, 32'h0);
        check("t6_rst_ferr", {31'h0, frame_err}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        rx = 1'b1;
        wait_negs(10);
        rst_n = 1'b1;
        wait_negs(2 * BIT_CLKS);
        check("t6_idle_rdy", {31'h0, rdy}, 32'h0);
        align();
        send_frame(8'hC9, 1'b1);
        check("t6_data", {24'h0, data}, 32'hC9);
        check("t6_rdy", {31'h0, rdy}, 32'h1);
        check("t6_ferr", {31'h0, frame_err}, 32'h0);
        check("t6_ovr", {31'h0, overrun}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
